flexdpe_out_compactor: RTL

Downstream stage of the FLEX-DPE output port. Consumes the sparse per-lane reduction outputs: NUM_PES lanes, each with its own valid bit, any subset valid per cycle. Compacts valid lanes in ascending lane order into a circular buffer. Drains the buffer as OUT_WORDS-wide valid/ready beats toward write-back, and gives an almost-full indication to the feeding controller.

---
 rtl/flexdpe_pkg.sv | 35 +++
 rtl/flexdpe_lane_rank.sv | 38 +++
 rtl/flexdpe_out_compactor.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/flexdpe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flexdpe_pkg
// Purpose  : Shared definitions for the FLEX-DPE output compactor: default
//            sizes, the buffer-entry layout and occupancy/count widths.
// Options  : FLEXDPE_LANE_TAG_EN - buffer entries carry a source-lane tag.
// Revision : 1.0 - initial release
// ============================================================================
package flexdpe_pkg;

    localparam int DEF_DATA_TYPE  = 32;   // one FP32 output word
    localparam int DEF_NUM_PES    = 32;   // reduction lanes
    localparam int DEF_LOG2_PES   = 5;
    localparam int DEF_OUT_WORDS  = 4;    // words per output beat
    localparam int DEF_LOG2_OUT   = 2;
    localparam int DEF_DEPTH      = 128;  // buffer words
    localparam int DEF_LOG2_DEPTH = 7;

    // Occupancy counts 0..DEPTH inclusive, so it needs one extra bit.
    typedef logic [DEF_LOG2_DEPTH:0] occ_t;
    // Beat word count 0..OUT_WORDS inclusive.
    typedef logic [DEF_LOG2_OUT:0]   count_t;
    // Valid-lane total 0..NUM_PES inclusive.
    typedef logic [DEF_LOG2_PES:0]   nin_t;

    // One buffered word; the tag names the lane the word came from.
    typedef struct packed {
`ifdef FLEXDPE_LANE_TAG_EN
        logic [DEF_LOG2_PES-1:0]  tag;
`endif
        logic [DEF_DATA_TYPE-1:0] data;
    } buf_entry_t;

endpackage
`default_nettype wire

// File: rtl/flexdpe_lane_rank.sv
`default_nettype none
// ============================================================================
// Module   : flexdpe_lane_rank
// Purpose  : Combinational prefix count over the per-lane valid mask. Each
//            lane's rank is the number of valid lanes below it, giving its
//            slot in the compacted write; o_n_in is the total valid count.
// Ports    : i_valid    [NUM_PES]           per-lane valid mask
//            o_rank_bus [NUM_PES*LOG2_PES]  rank of lane k at [k*LOG2_PES +: LOG2_PES]
//            o_n_in     [LOG2_PES+1]        number of valid lanes (0..NUM_PES)
// Revision : 1.0 - initial release
// ============================================================================
module flexdpe_lane_rank
    import flexdpe_pkg::*;
#(
    parameter int NUM_PES  = DEF_NUM_PES,
    parameter int LOG2_PES = DEF_LOG2_PES
) (
    input  logic [NUM_PES-1:0]          i_valid,
    output logic [NUM_PES*LOG2_PES-1:0] o_rank_bus,
    output logic [LOG2_PES:0]           o_n_in
);

    logic [LOG2_PES:0] w_acc;

    // Running sum: rank of lane k is taken before lane k's own bit is added,
    // so it never exceeds NUM_PES-1 and fits in LOG2_PES bits.
    always_comb begin
        w_acc      = '0;
        o_rank_bus = '0;
        for (int k = 0; k < NUM_PES; k++) begin
            o_rank_bus[k*LOG2_PES +: LOG2_PES] = w_acc[LOG2_PES-1:0];
            w_acc = w_acc + {{LOG2_PES{1'b0}}, i_valid[k]};
        end
        o_n_in = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/flexdpe_out_compactor.sv
`default_nettype none
// ============================================================================
// Module   : flexdpe_out_compactor
// Purpose  : FLEX-DPE output port compactor. Registers the sparse per-lane
//            reduction outputs, packs the valid lanes (ascending lane order)
//            into a circular buffer and drains it as OUT_WORDS-wide
//            valid/ready beats. Flags almost-full to the feeding controller
//            and records dropped input beats in a sticky overflow flag.
// Options  : FLEXDPE_LANE_TAG_EN - store the source-lane index with every
//            word and present it on o_tag_bus.
// Ports    : clk, rst (synchronous, active-low), i_clear (synchronous flush)
//            i_valid / i_data_bus       per-lane input
//            o_almost_full / o_overflow / o_occupancy  status
//            o_valid / o_count / o_data_bus [/ o_tag_bus], i_ready  beat out
// Revision : 1.0 - initial release
// ============================================================================
module flexdpe_out_compactor
    import flexdpe_pkg::*;
#(
    parameter int DATA_TYPE  = DEF_DATA_TYPE,
    parameter int NUM_PES    = DEF_NUM_PES,
    parameter int LOG2_PES   = DEF_LOG2_PES,
    parameter int OUT_WORDS  = DEF_OUT_WORDS,
    parameter int LOG2_OUT   = DEF_LOG2_OUT,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOG2_DEPTH = DEF_LOG2_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PES-1:0]             i_valid,
    input  logic [NUM_PES*DATA_TYPE-1:0]   i_data_bus,
    input  logic                           i_clear,
    output logic                           o_almost_full,
    output logic                           o_overflow,
    output logic [LOG2_DEPTH:0]            o_occupancy,
    output logic                           o_valid,
    output logic [LOG2_OUT:0]              o_count,
    output logic [OUT_WORDS*DATA_TYPE-1:0] o_data_bus,
`ifdef FLEXDPE_LANE_TAG_EN
    output logic [OUT_WORDS*LOG2_PES-1:0]  o_tag_bus,
`endif
    input  logic                           i_ready
);

    localparam int c_af_thresh = 2 * NUM_PES;

    typedef logic [LOG2_DEPTH-1:0] ptr_t;
    typedef logic [LOG2_DEPTH:0]   occ_w_t;

    typedef struct packed {
`ifdef FLEXDPE_LANE_TAG_EN
        logic [LOG2_PES-1:0]  tag;
`endif
        logic [DATA_TYPE-1:0] data;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_PES-1:0]             r_s1_valid;
    logic [NUM_PES*DATA_TYPE-1:0]   r_s1_data;
    ptr_t                           r_wr_ptr;
    ptr_t                           r_rd_ptr;
    occ_w_t                         r_occ;
    logic                           r_overflow;
    logic                           r_out_valid;
    logic [LOG2_OUT:0]              r_out_count;
    logic [OUT_WORDS*DATA_TYPE-1:0] r_out_data;
    entry_t [DEPTH-1:0]             r_mem;
`ifdef FLEXDPE_LANE_TAG_EN
    logic [OUT_WORDS*LOG2_PES-1:0]  r_out_tag;
    logic [OUT_WORDS*LOG2_PES-1:0]  w_out_tag_next;
`endif

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic                           w_flush;
    logic [NUM_PES*LOG2_PES-1:0]    w_rank_bus;
    logic [LOG2_PES:0]              w_n_in;
    occ_w_t                         w_free;
    logic                           w_drop;
    logic                           w_write;
    logic                           w_load;
    logic [LOG2_OUT:0]              w_load_cnt;
    occ_w_t                         w_occ_next;
    entry_t [NUM_PES-1:0]           w_lane_entry;
    ptr_t   [NUM_PES-1:0]           w_lane_addr;
    entry_t [OUT_WORDS-1:0]         w_rd_entry;
    entry_t [DEPTH-1:0]             w_mem_next;
    logic [OUT_WORDS*DATA_TYPE-1:0] w_out_data_next;

    assign w_flush = !rst || i_clear;

    flexdpe_lane_rank #(
        .NUM_PES  (NUM_PES),
        .LOG2_PES (LOG2_PES)
    ) u_lane_rank (
        .i_valid    (r_s1_valid),
        .o_rank_bus (w_rank_bus),
        .o_n_in     (w_n_in)
    );

    // Free space is taken before this cycle's output load; a beat that would
    // only fit thanks to the concurrent pop is still dropped.
    assign w_free  = occ_w_t'(DEPTH) - r_occ;
    assign w_drop  = occ_w_t'(w_n_in) > w_free;
    assign w_write = (w_n_in != '0) && !w_drop;

    assign w_load  = (!r_out_valid || i_ready) && (r_occ != '0);

    always_comb begin
        w_load_cnt = '0;
        if (w_load) begin
            if (r_occ >= occ_w_t'(OUT_WORDS)) begin
                w_load_cnt = (LOG2_OUT+1)'(OUT_WORDS);
            end else begin
                w_load_cnt = r_occ[LOG2_OUT:0];
            end
        end
    end

    assign w_occ_next = r_occ + (w_write ? occ_w_t'(w_n_in) : '0) - occ_w_t'(w_load_cnt);

    // Per-lane buffer entry and compacted write address.
    for (genvar k = 0; k < NUM_PES; k++) begin : g_lane
        assign w_lane_entry[k].data = r_s1_data[k*DATA_TYPE +: DATA_TYPE];
`ifdef FLEXDPE_LANE_TAG_EN
        assign w_lane_entry[k].tag  = LOG2_PES'(k);
`endif
        assign w_lane_addr[k] = r_wr_ptr + ptr_t'(w_rank_bus[k*LOG2_PES +: LOG2_PES]);
    end

    // Words offered to the output register, oldest first.
    for (genvar i = 0; i < OUT_WORDS; i++) begin : g_rd
        assign w_rd_entry[i] = r_mem[r_rd_ptr + ptr_t'(i)];
    end

    // Valid lanes have distinct ranks, so the compacted writes never collide.
    always_comb begin
        w_mem_next = r_mem;
        if (w_write) begin
            for (int k = 0; k < NUM_PES; k++) begin
                if (r_s1_valid[k]) begin
                    w_mem_next[w_lane_addr[k]] = w_lane_entry[k];
                end
            end
        end
    end

    // Unused beat slots are forced to zero.
    always_comb begin
        w_out_data_next = '0;
`ifdef FLEXDPE_LANE_TAG_EN
        w_out_tag_next  = '0;
`endif
        for (int i = 0; i < OUT_WORDS; i++) begin
            if (i < int'(w_load_cnt)) begin
                w_out_data_next[i*DATA_TYPE +: DATA_TYPE] = w_rd_entry[i].data;
`ifdef FLEXDPE_LANE_TAG_EN
                w_out_tag_next[i*LOG2_PES +: LOG2_PES]    = w_rd_entry[i].tag;
`endif
            end
        end
    end

    // Storage has no reset: entries are only read once occupancy covers them.
    always_ff @(posedge clk) begin
        r_mem <= w_mem_next;
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_s1_valid  <= '0;
            r_s1_data   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_count <= '0;
            r_out_data  <= '0;
`ifdef FLEXDPE_LANE_TAG_EN
            r_out_tag   <= '0;
`endif
        end else begin
            r_s1_valid <= i_valid;
            r_s1_data  <= i_data_bus;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(w_n_in);
            end
            r_rd_ptr <= r_rd_ptr + ptr_t'(w_load_cnt);
            r_occ    <= w_occ_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_count <= w_load_cnt;
                r_out_data  <= w_out_data_next;
`ifdef FLEXDPE_LANE_TAG_EN
                r_out_tag   <= w_out_tag_next;
`endif
            end else if (r_out_valid && i_ready) begin
                // Beat taken with nothing buffered behind it.
                r_out_valid <= 1'b0;
                r_out_count <= '0;
                r_out_data  <= '0;
`ifdef FLEXDPE_LANE_TAG_EN
                r_out_tag   <= '0;
`endif
            end
        end
    end

    assign o_almost_full = w_free < occ_w_t'(c_af_thresh);
    assign o_overflow    = r_overflow;
    assign o_occupancy   = r_occ;
    assign o_valid       = r_out_valid;
    assign o_count       = r_out_count;
    assign o_data_bus    = r_out_data;
`ifdef FLEXDPE_LANE_TAG_EN
    assign o_tag_bus     = r_out_tag;
`endif

endmodule
`default_nettype wire
